// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   ILEN       : instruction width
//   PC_STEP    : byte increment between sequential fetches
//   FQ_XLEN    : PC width held in an instruction-queue entry (RV32)
//   fq_entry_t : one instruction-queue entry {instr, pc}
package fetch_pkg;

    localparam int ILEN    = 32;
    localparam int PC_STEP = 4;
    localparam int FQ_XLEN = 32;

    typedef struct packed {
        logic [ILEN-1:0]    instr;
        logic [FQ_XLEN-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_sync_fifo.sv
// Synchronous FIFO used both as the instruction queue and as the in-flight
// PC tag FIFO. DEPTH need not be a power of two; pointers wrap explicitly.
// Push into a full FIFO and pop from an empty FIFO are ignored. Flush empties
// the FIFO and overrides push/pop in the same cycle.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (control state only)
//   push, wdata  : write request and data
//   pop          : remove head entry
//   flush        : discard all entries
//   rdata        : head entry (valid while count != 0)
//   count        : number of stored entries, 0..DEPTH
module fetch_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign rdata   = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage carries data only and is never reset; count gates its use.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_queue_frontend.sv
// Decoupled instruction-fetch front end: fetch-PC register, up to
// MAX_OUTSTANDING pipelined imem requests, and a DEPTH-entry instruction
// queue feeding decode over valid/ready. Redirects flush the queue and
// squash in-flight responses.
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_squashed.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     : fetch request channel
//   imem_rsp_valid/data           : in-order response, no backpressure
//   redirect_valid/pc             : one-cycle redirect from execute
//   dec_valid/ready/instr/pc      : instruction queue head to decode
//   perf_fetched/perf_squashed    : saturating counters (FETCH_PERF_EN only)
//   o_empty, o_full               : queue occupancy flags
module fetch_queue_frontend
    import fetch_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic            o_empty,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed,
`endif
    output logic            o_full
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);

    logic [XLEN-1:0] fetch_pc;
    logic [OW-1:0]   drop_cnt;
    logic [OW-1:0]   tag_count;
    logic [OW-1:0]   outstanding;
    logic [CW-1:0]   q_count;
    logic [XLEN-1:0] tag_head;
    fq_entry_t       q_wdata;
    fq_entry_t       q_head;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_known;
    logic            rsp_drop;
    logic            rsp_live;
    logic            q_push;
    logic            q_pop;

    // The tag FIFO only holds PCs of live requests; squashed requests are
    // tracked by drop_cnt alone, so the two together give the in-flight total.
    assign outstanding = tag_count + drop_cnt;

    // A response is only meaningful if something is actually in flight;
    // anything else (stale pre-reset data, protocol error) is ignored.
    assign rsp_known = imem_rsp_valid && (outstanding != '0);
    assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_live  = imem_rsp_valid && (drop_cnt == '0) && (tag_count != '0);

    // Credit covers queue entries plus in-flight requests, so every response
    // that is eventually accepted is guaranteed a free queue slot.
    assign credit_ok = (32'(outstanding) < MAX_OUTSTANDING) &&
                       ((32'(q_count) + 32'(outstanding)) < DEPTH);

    assign imem_req_valid = reset_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign dec_valid = (q_count != '0);
    assign q_pop     = dec_valid && dec_ready && !redirect_valid;
    assign q_push    = rsp_live && !redirect_valid;
    assign q_wdata   = '{instr: imem_rsp_data, pc: FQ_XLEN'(tag_head)};

    // Outputs read zero while the queue is empty so reset state is clean
    // even though the queue storage itself is not reset.
    assign dec_instr = dec_valid ? q_head.instr : '0;
    assign dec_pc    = dec_valid ? XLEN'(q_head.pc) : '0;
    assign o_empty   = (q_count == '0);
    assign o_full    = (q_count == CW'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
            // Everything still in flight after this cycle's response is stale.
            drop_cnt <= outstanding - OW'(rsp_known);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    fetch_sync_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (q_push),
        .pop     (q_pop),
        .flush   (redirect_valid),
        .wdata   (q_wdata),
        .rdata   (q_head),
        .count   (q_count)
    );

    fetch_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (req_fire),
        .pop     (rsp_live),
        .flush   (redirect_valid),
        .wdata   (fetch_pc),
        .rdata   (tag_head),
        .count   (tag_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] squash_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    // A discarded response (stale, or arriving with a redirect) plus every
    // queue entry thrown away by the flush.
    assign squash_inc = 32'(rsp_known && (rsp_drop || redirect_valid)) +
                        (redirect_valid ? 32'(q_count) : 32'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            perf_fetched  <= sat_add(perf_fetched, 32'(q_pop));
            perf_squashed <= sat_add(perf_squashed, squash_inc);
        end
    end
`endif

endmodule
